// File: rtl/desired_drive_ramp.sv
// Assist-current calculator: clamps the sensor inputs, forms a saturated
// torque*cadence*incline*setting product over a valid-tagged pipeline, then slew-limits it.
module desired_drive_ramp #(
  parameter int                  TORQUE_W    = 12,
  parameter logic [TORQUE_W-1:0] TORQUE_MIN  = 'h380,
  parameter int                  INCL_W      = 13,
  parameter int                  CAD_W       = 5,
  parameter int                  CAD_OFFSET  = 32,
  parameter int                  INCL_OFFSET = 256,
  parameter int                  SET_W       = 2,
  parameter int                  OUT_W       = 12,
  parameter int                  SHIFT       = 14,
  parameter int                  RAMP_UP     = 64,
  parameter int                  RAMP_DN     = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic [TORQUE_W-1:0]      avg_torque,
  input  logic [CAD_W-1:0]         cadence_vec,
  input  logic signed [INCL_W-1:0] incline,
  input  logic [SET_W-1:0]         setting,
  input  logic                     brake,
  output logic                     out_vld,
  output logic [OUT_W-1:0]         target_curr,
  output logic                     raw_sat
);

  localparam int CF_W = CAD_W + 1;
  localparam int IL_W = 9;
  localparam int P2_W = CF_W + IL_W;
  localparam int P3_W = P2_W + TORQUE_W;
  localparam int P4_W = P3_W + SET_W;
  localparam int TOP  = SHIFT + OUT_W;

  // Input capture stage keeps the clamp logic off the sensor-block paths.
  logic                     vld0;
  logic [TORQUE_W-1:0]      torque0;
  logic [CAD_W-1:0]         cad0;
  logic signed [INCL_W-1:0] incl0;
  logic [SET_W-1:0]         set0;

  logic                vld1, vld2, vld3, vld4;
  logic [TORQUE_W-1:0] tp1, tp2;
  logic [CF_W-1:0]     cf1;
  logic [IL_W-1:0]     il1;
  logic [SET_W-1:0]    set1, set2, set3;
  logic [P2_W-1:0]     ci2;
  logic [P3_W-1:0]     p3;
  logic [OUT_W-1:0]    raw4;
  logic                sat4;

  int                  incl_sat_c, incl_lim_c;
  logic [IL_W-1:0]     il_c;
  logic [CF_W-1:0]     cf_c;
  logic [TORQUE_W-1:0] tp_c;
  logic [P4_W-1:0]     prod4_c;
  logic                sat4_c;
  logic [OUT_W-1:0]    raw4_c;
  logic [OUT_W-1:0]    up_diff, dn_diff, ramp_c;

  always_comb begin
    incl_sat_c = int'(incl0);
    if (incl_sat_c > 511)       incl_sat_c = 511;
    else if (incl_sat_c < -512) incl_sat_c = -512;
    incl_lim_c = incl_sat_c + INCL_OFFSET;
    if (incl_lim_c > 511)       incl_lim_c = 511;
    else if (incl_lim_c < 0)    incl_lim_c = 0;
    il_c = IL_W'(incl_lim_c);
    cf_c = (cad0[CAD_W-1:1] == '0) ? '0 : CF_W'(cad0) + CF_W'(CAD_OFFSET);
    tp_c = (torque0 > TORQUE_MIN) ? torque0 - TORQUE_MIN : '0;
  end

  always_comb begin
    prod4_c = P4_W'(p3) * P4_W'(set3);
    sat4_c  = (prod4_c >> TOP) != '0;
    raw4_c  = sat4_c ? '1 : prod4_c[TOP-1:SHIFT];
  end

  // Steps never overshoot raw, so the result stays inside [0, 2^OUT_W-1].
  always_comb begin
    up_diff = raw4 - target_curr;
    dn_diff = target_curr - raw4;
    ramp_c  = target_curr;
    if (raw4 > target_curr)
      ramp_c = target_curr + ((up_diff > OUT_W'(RAMP_UP)) ? OUT_W'(RAMP_UP) : up_diff);
    else if (raw4 < target_curr)
      ramp_c = target_curr - ((dn_diff > OUT_W'(RAMP_DN)) ? OUT_W'(RAMP_DN) : dn_diff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {vld0, vld1, vld2, vld3, vld4} <= '0;
    end else if (brake) begin
      {vld0, vld1, vld2, vld3, vld4} <= '0;
    end else begin
      vld0 <= in_vld;
      vld1 <= vld0;
      vld2 <= vld1;
      vld3 <= vld2;
      vld4 <= vld3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      torque0 <= '0; cad0 <= '0; incl0 <= '0; set0 <= '0;
      tp1 <= '0; cf1 <= '0; il1 <= '0; set1 <= '0;
      ci2 <= '0; tp2 <= '0; set2 <= '0;
      p3 <= '0; set3 <= '0;
      raw4 <= '0; sat4 <= 1'b0;
    end else begin
      torque0 <= avg_torque; cad0 <= cadence_vec; incl0 <= incline; set0 <= setting;
      tp1 <= tp_c; cf1 <= cf_c; il1 <= il_c; set1 <= set0;
      ci2 <= P2_W'(cf1) * P2_W'(il1); tp2 <= tp1; set2 <= set1;
      p3 <= P3_W'(ci2) * P3_W'(tp2); set3 <= set2;
      raw4 <= raw4_c; sat4 <= sat4_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_curr <= '0;
      out_vld     <= 1'b0;
      raw_sat     <= 1'b0;
    end else if (brake) begin
      target_curr <= '0;
      out_vld     <= 1'b0;
      raw_sat     <= 1'b0;
    end else begin
      out_vld <= vld4;
      raw_sat <= vld4 & sat4;
      if (vld4) target_curr <= ramp_c;
    end
  end

endmodule

// File: tb/tb_desired_drive_ramp.sv
// Bench for desired_drive_ramp: directed plan steps plus random traffic against
// an arithmetic model with a queue of pending samples due five edges after acceptance.
module tb_desired_drive_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [11:0] avg_torque;
  logic [4:0]  cadence_vec;
  logic [12:0] incline;
  logic [1:0]  setting;
  logic        brake;
  logic        out_vld;
  logic [11:0] target_curr;
  logic        raw_sat;

  desired_drive_ramp dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .avg_torque(avg_torque),
    .cadence_vec(cadence_vec), .incline(incline), .setting(setting),
    .brake(brake), .out_vld(out_vld), .target_curr(target_curr), .raw_sat(raw_sat)
  );

  always #5 clk = ~clk;

  typedef struct {int raw; bit sat; int due;} ent_t;
  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   mt = 0;
  bit   exp_vld, exp_sat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  function automatic void model_raw(input int tq, input int cd, input int ic, input int st,
                                    output int raw, output bit sat);
    int isat, il, cf, tp;
    longint prod;
    isat = (ic > 511) ? 511 : ((ic < -512) ? -512 : ic);
    il   = isat + 256;
    il   = (il > 511) ? 511 : ((il < 0) ? 0 : il);
    cf   = (cd / 2 == 0) ? 0 : cd + 32;
    tp   = (tq > 'h380) ? tq - 'h380 : 0;
    prod = longint'(tp) * cf * il * st;
    sat  = prod >= (longint'(1) << 26);
    raw  = sat ? 4095 : int'((prod >> 14) % 4096);
  endfunction

  task automatic step(input bit v, input int tq, input int cd, input int ic, input int st,
                      input bit br);
    int r;
    bit s;
    ent_t e;
    in_vld = v; avg_torque = 12'(tq); cadence_vec = 5'(cd);
    incline = 13'(ic); setting = 2'(st); brake = br;
    @(posedge clk);
    edge_cnt++;
    exp_vld = 1'b0;
    exp_sat = 1'b0;
    if (br) begin
      q.delete();
      mt = 0;
    end else begin
      if (q.size() > 0 && q[0].due == edge_cnt) begin
        e = q.pop_front();
        if (e.raw > mt)      mt = mt + ((e.raw - mt > 64) ? 64 : e.raw - mt);
        else if (e.raw < mt) mt = mt - ((mt - e.raw > 128) ? 128 : mt - e.raw);
        exp_vld = 1'b1;
        exp_sat = e.sat;
      end
      if (v) begin
        model_raw(tq, cd, ic, st, r, s);
        q.push_back('{raw: r, sat: s, due: edge_cnt + 5});
      end
    end
    #1;
    check("out_vld", out_vld, exp_vld);
    check("raw_sat", raw_sat, exp_sat);
    check("target_curr", target_curr, mt);
    $display("edge %0d in_vld=%0b brake=%0b -> out_vld=%0b raw_sat=%0b target=%0d",
             edge_cnt, v, br, out_vld, raw_sat, target_curr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic nominal(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 'h480, 16, 0, 2, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; avg_torque = '0; cadence_vec = '0;
    incline = '0; setting = '0; brake = 1'b0;
    #12;
    check("reset out_vld", out_vld, 0);
    check("reset target", target_curr, 0);
    @(posedge clk); #2 rst = 1'b0;

    // Nominal ramp: 64..384 then hold.
    nominal(12);
    idle(6);
    check("nominal final", target_curr, 384);

    // Brake with samples in flight.
    nominal(3);
    step(1'b1, 'h480, 16, 0, 2, 1'b1);
    check("brake clears", target_curr, 0);
    step(1'b1, 'h480, 16, 0, 2, 1'b1);
    idle(2);
    nominal(8);
    idle(6);

    // Saturation up to full scale, then setting 0 ramps down.
    for (int i = 0; i < 70; i++) step(1'b1, 'hFFF, 31, 'h0FFF, 3, 1'b0);
    idle(6);
    check("sat full scale", target_curr, 4095);
    for (int i = 0; i < 36; i++) step(1'b1, 'hFFF, 31, 'h0FFF, 0, 1'b0);
    idle(6);
    check("setting0 zero", target_curr, 0);

    // Input clamps.
    for (int i = 0; i < 6; i++) step(1'b1, 'h380, 16, 0, 2, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 'h480, 1, 0, 2, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 'h480, 16, -300, 2, 1'b0);
    idle(6);
    check("clamps stay zero", target_curr, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 'h480, 16, 4000, 1, 1'b0);
    idle(6);
    check("incline 4000", target_curr, 383);

    // Sparse input every 7th cycle.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 'h480, 16, 0, 2, 1'b0);
      idle(6);
    end

    // Random traffic with occasional brake.
    for (int i = 0; i < 400; i++) begin
      int ic;
      ic = int'($urandom_range(0, 8191)) - 4096;
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 31)), ic, int'($urandom_range(0, 3)),
           $urandom_range(0, 31) == 0);
    end
    idle(6);

    // Reset mid-stream.
    nominal(8);
    in_vld = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("midreset out_vld", out_vld, 0);
    check("midreset target", target_curr, 0);
    check("midreset raw_sat", raw_sat, 0);
    q.delete();
    mt = 0;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
